// File: rtl/mux6_pkg.sv
// Shared types, select encodings and round-robin helpers for the
// six-requester mux arbiter.
package mux6_pkg;

   localparam int N_REQ = 6;

   typedef logic [2:0] sel_t;

   localparam sel_t SEL_0 = 3'b000;
   localparam sel_t SEL_1 = 3'b001;
   localparam sel_t SEL_2 = 3'b010;
   localparam sel_t SEL_3 = 3'b011;
   localparam sel_t SEL_4 = 3'b100;
   localparam sel_t SEL_5 = 3'b101;

   typedef enum logic {IDLE, FULL} arb_state_t;

   typedef struct packed {
      logic valid;
      sel_t idx;
   } pick_t;

   // Scanning from the far end toward ptr lets the closest set request
   // overwrite the result, so no early exit is needed.
   function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input sel_t ptr);
      pick_t p;
      int    pos;
      p.valid = 1'b0;
      p.idx   = SEL_0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N_REQ) begin
            pos = pos - N_REQ;
         end
         if (req[pos]) begin
            p.valid = 1'b1;
            p.idx   = sel_t'(pos);
         end
      end
      return p;
   endfunction

   function automatic sel_t next_ptr(input sel_t idx);
      return (idx == SEL_5) ? SEL_0 : sel_t'(idx + 3'd1);
   endfunction

   function automatic logic [N_REQ-1:0] sel_onehot(input sel_t idx);
      logic [N_REQ-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/mux6_rr_arbiter_if.sv
// Producer-side request/data bundle plus the downstream valid/ready stage
// of the six-input mux arbiter.
interface mux6_rr_arbiter_if #(parameter int WIDTH = 8) ();
   import mux6_pkg::*;

   logic [N_REQ-1:0] req;
   logic [WIDTH-1:0] in_0;
   logic [WIDTH-1:0] in_1;
   logic [WIDTH-1:0] in_2;
   logic [WIDTH-1:0] in_3;
   logic [WIDTH-1:0] in_4;
   logic [WIDTH-1:0] in_5;
   logic [N_REQ-1:0] ack;
   sel_t             ctrl;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output req, in_0, in_1, in_2, in_3, in_4, in_5, out_ready,
      input  ack, ctrl, out_data, out_valid
   );

   modport slave (
      input  req, in_0, in_1, in_2, in_3, in_4, in_5, out_ready,
      output ack, ctrl, out_data, out_valid
   );

endinterface

// File: rtl/mux_6x1.sv
// Six-to-one word multiplexer; the unused select codes yield zero.
module mux_6x1
   import mux6_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  sel_t             ctrl,
   input  logic [WIDTH-1:0] in_0,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   input  logic [WIDTH-1:0] in_3,
   input  logic [WIDTH-1:0] in_4,
   input  logic [WIDTH-1:0] in_5,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      out = '0;
      case (ctrl)
         SEL_0:   out = in_0;
         SEL_1:   out = in_1;
         SEL_2:   out = in_2;
         SEL_3:   out = in_3;
         SEL_4:   out = in_4;
         SEL_5:   out = in_5;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin sequencer that shares one mux_6x1 among six requesters and
// registers the chosen word into a single valid/ready output slot.
module mux6_rr_arbiter
   import mux6_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   mux6_rr_arbiter_if.slave bus
);

   arb_state_t       state_q;
   arb_state_t       state_d;
   sel_t             ptr_q;
   sel_t             ctrl_q;
   sel_t             ctrl_sel;
   pick_t            pick;
   logic             load;
   logic [N_REQ-1:0] ack_d;
   logic             valid_d;
   logic [WIDTH-1:0] mux_out;
   logic [WIDTH-1:0] data_q;

   // Gating with rst_n keeps ack quiet while reset is held with requests up.
   assign pick = rr_pick(bus.req, ptr_q);
   assign load = rst_n && pick.valid && ((state_q == IDLE) || bus.out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (load) begin
               state_d = FULL;
            end else if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Select follows the winner only in a load cycle, otherwise it parks.
   always_comb begin
      ack_d    = '0;
      ctrl_sel = ctrl_q;
      valid_d  = (state_q == FULL);
      if (load) begin
         ack_d    = sel_onehot(pick.idx);
         ctrl_sel = pick.idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         ptr_q  <= SEL_0;
         ctrl_q <= SEL_0;
      end else if (load) begin
         data_q <= mux_out;
         ptr_q  <= next_ptr(pick.idx);
         ctrl_q <= pick.idx;
      end
   end

   mux_6x1 #(
      .WIDTH (WIDTH)
   ) u_mux (
      .ctrl (ctrl_sel),
      .in_0 (bus.in_0),
      .in_1 (bus.in_1),
      .in_2 (bus.in_2),
      .in_3 (bus.in_3),
      .in_4 (bus.in_4),
      .in_5 (bus.in_5),
      .out  (mux_out)
   );

   assign bus.ack       = ack_d;
   assign bus.ctrl      = ctrl_sel;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_d;

endmodule

// File: doc/mux6_rr_arbiter.md
# mux6_rr_arbiter

Round-robin arbiter and sequencer for the six-input `mux_6x1` datapath. It shares the single 8-bit mux output among six requesters and drives the mux `ctrl` select, one requester per transfer. It registers the selected word into a valid/ready output stage and pulses a per-requester acknowledge when that requester's word is captured. It sits between the six producer ports and one downstream consumer.

## Interface
- `WIDTH`, 8, data width of each mux input and of `out_data`
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `req`  input  6  `req[i]` high: requester i holds valid data on `in_i`
- `in_0` … `in_5`  input  WIDTH each  requester data, stable while `req[i]` is high
- `ack`  output  6  one-hot, single-cycle pulse: requester i's word was captured this edge
- `ctrl`  output  3  mux select sent to `mux_6x1`: 3'b000–3'b101 only
- `out_data`  output  WIDTH  registered selected word
- `out_valid`  output  1  `out_data` holds an unconsumed word
- `out_ready`  input  1  downstream accepts `out_data` when high with `out_valid`

## Operation
- States: IDLE (`out_valid`=0) and FULL (`out_valid`=1).
- The load condition is `(!out_valid || out_ready) && |req`.
- On load:
  - The winner is the first set `req[i]` searching from `ptr` upward, modulo 6.
  - `ctrl` equals the winner index combinationally in that cycle.
  - `out_data` is loaded with the `mux_6x1` output.
  - `ack[winner]` is 1 for that cycle.
  - `ptr` is set to (winner+1) mod 6; 5 wraps to 0.
  - The state goes to FULL.
- In FULL with `out_ready`=0: `out_data` and `out_valid` hold, `ack`=0, and no arbitration occurs.
- In FULL with `out_ready`=1:
  - If any `req` is set, a new word loads in the same cycle (back-to-back transfer, state stays FULL).
  - Otherwise the state goes to IDLE.
- When no load occurs, `ctrl` holds its last value, so the mux select does not toggle needlessly.
- `ptr` resets to 0; requester 0 has top priority after reset.
- A requester must drop `req` or present its next word in the cycle after its `ack`. The arbiter does not track outstanding requests beyond `req`.
- Codes 3'b110 and 3'b111 are never driven on `ctrl`.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on deassert):
  - `out_valid`=0, `out_data`=0, `ack`=0, `ctrl`=3'b000, `ptr`=0, state IDLE.
- Reset asserted mid-transfer discards the held word. No `ack` is re-issued.
- Latency: a `req` asserted in cycle n while IDLE gives `ack` in cycle n and `out_valid`=1 from cycle n+1.
- Throughput: one word per cycle while `out_ready` stays high and requests are present.
- `ack` is combinational from `req`, `ptr`, `out_valid` and `out_ready`. It asserts only in a load cycle and is never asserted for more than one requester.
- If `req[i]` falls in a cycle where it would have won, the next set request in round-robin order wins instead. There is no glitch on `out_valid`.

## Structure
- A shared package `mux6_pkg` holds:
  - `localparam N_REQ = 6`
  - `typedef logic [2:0] sel_t`
  - the `ctrl` encodings `SEL_0`…`SEL_5`
  - `typedef enum {IDLE, FULL} arb_state_t`
- The single sub-module is the existing `mux_6x1`, instantiated once with `ctrl` and `in_0`…`in_5`.
- The round-robin search is a function in the package, `rr_pick(req, ptr)`, which returns a valid flag and the index.

## Test plan
- Reset then a single request:
  - Stimulus: `in_i`=i+8'h10, `req`=6'b000100 for one cycle, `out_ready`=1.
  - Response: `ctrl`=3'b010 and `ack`=6'b000100 in that cycle; next cycle `out_data`=8'h12 and `out_valid`=1.
- All six requesting continuously, `out_ready`=1:
  - Response: `ack` walks 0,1,2,3,4,5,0.
  - `out_data` sequence is 8'h10…8'h15, then 8'h10, one per cycle.
- Backpressure:
  - Stimulus: `req`=6'b100001, `out_ready`=0 for 4 cycles after the first load.
  - Response: `out_data`=8'h10 holds and `ack` stays 0.
  - On `out_ready`=1, 8'h15 loads and `ack[5]` pulses.
- Wrap-around:
  - Stimulus: after requester 5 is served, `req`=6'b100001.
  - Response: requester 0 wins.
- Reset while FULL with `req`=6'b111111:
  - Response: all outputs return to reset values immediately.
  - After release, the first `ack` goes to requester 0.
- Idle drain:
  - Stimulus: one word loaded, `req`=0, `out_ready`=1.
  - Response: `out_valid` falls the next cycle and `ctrl` holds its last value.
